// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: state encoding and
// the default payload width. States are encoded as {skid_v, main_v}.
package pipe_pkg;

   localparam int PIPE_W_DEFAULT = 32;

   // 2'b10 (skid valid without main valid) is unreachable by construction.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } skid_state_t;

   // Main register holds a payload in ONE and TWO.
   function automatic logic state_main_v(input skid_state_t s);
      return (s != EMPTY);
   endfunction

   // Skid register holds a payload only in TWO.
   function automatic logic state_skid_v(input skid_state_t s);
      return (s == TWO);
   endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with clock enable and asynchronous active-high
// reset to zero. Used for both the main and the skid payload slots.
module pipe_data_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = PIPE_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Load only when enabled; stale contents are kept otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with valid/ready on both sides and a two-entry
// skid buffer, so in_ready is decoded from state only and never depends
// combinationally on out_ready.
// Optional feature: define PIPE_SKID_FLUSH_EN to add the synchronous
// flush input that discards all held payloads.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = PIPE_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic             flush,
`endif
   output logic [WIDTH-1:0] out_data
);

   skid_state_t      r_state;
   skid_state_t      w_state_next;
   logic             w_main_v;
   logic             w_skid_v;
   logic             w_flush;
   logic             w_acc;
   logic             w_pop;
   logic             w_main_en;
   logic             w_skid_en;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

`ifdef PIPE_SKID_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_main_v = state_main_v(r_state);
   assign w_skid_v = state_skid_v(r_state);

   // Ready is a pure decode of the state register (plus the flush mask).
   assign in_ready  = !w_skid_v && !w_flush;
   assign w_acc     = in_valid && in_ready;
   assign w_pop     = w_main_v && out_ready;

   assign out_valid = w_main_v;
   assign out_data  = w_main_q;

   // State register; reset empties the buffer immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and data-register load controls.
   always_comb begin
      w_state_next = r_state;
      w_main_en    = 1'b0;
      w_skid_en    = 1'b0;
      w_main_d     = in_data;
      if (w_flush) begin
         // Flush wins over acc and pop; data registers keep stale contents.
         w_state_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_acc) begin
                  w_main_en    = 1'b1;
                  w_state_next = ONE;
               end
            end
            ONE: begin
               if (w_acc && w_pop) begin
                  w_main_en = 1'b1;
               end else if (w_acc) begin
                  w_skid_en    = 1'b1;
                  w_state_next = TWO;
               end else if (w_pop) begin
                  w_state_next = EMPTY;
               end
            end
            TWO: begin
               // No acc possible here: in_ready is low while skid is full.
               if (w_pop) begin
                  w_main_en    = 1'b1;
                  w_main_d     = w_skid_q;
                  w_state_next = ONE;
               end
            end
            default: begin
               w_state_next = EMPTY;
            end
         endcase
      end
   end

   pipe_data_reg #(.WIDTH(WIDTH)) u_main_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_main_en),
      .i_d  (w_main_d),
      .o_q  (w_main_q)
   );

   pipe_data_reg #(.WIDTH(WIDTH)) u_skid_reg (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_skid_en),
      .i_d  (in_data),
      .o_q  (w_skid_q)
   );

endmodule
